// File: rtl/sda_kernel_ctrl_pkg.sv
// Shared definitions for the kernel control register file: register map,
// CTRL bit positions, AXI response codes and the two FSM state types.
package sda_kernel_ctrl_pkg;

  localparam logic [7:0] CTRL_OFFSET = 8'h00;
  localparam logic [7:0] IE_OFFSET   = 8'h04;
  localparam logic [7:0] PARAM_BASE  = 8'h10;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_DONE_BIT  = 1;
  localparam int CTRL_IDLE_BIT  = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {A_IDLE, A_GO, A_RUN, A_ACK, A_DRAIN} action_state_t;
  typedef enum logic       {P_IDLE, P_RESP} param_state_t;

  // Word index relative to PARAM[0]; negative or too large means "not a parameter".
  function automatic int param_index(input logic [5:0] word);
    return int'(word) - int'(PARAM_BASE[7:2]);
  endfunction

endpackage

// File: rtl/sda_param_server.sv
// Serves the action's parameter reads: accepts one word index, then presents
// the captured parameter value until the action acknowledges it.
module sda_param_server
  import sda_kernel_ctrl_pkg::*;
#(
  parameter int NUM_PARAMS = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_PARAMS-1:0][31:0] params,
  input  logic                       paramaddr_0r0,
  input  logic [31:0]                paramaddr_0D,
  output logic                       paramaddr_0a,
  output logic                       paramdata_0r0,
  output logic [31:0]                paramdata_0D,
  input  logic                       paramdata_0a
);

  param_state_t state, state_next;
  logic         load;
  logic [31:0]  sel_value;
  logic [31:0]  data_q;
  logic         ack_q;

  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      P_IDLE: if (paramaddr_0r0) begin
        load       = 1'b1;
        state_next = P_RESP;
      end
      P_RESP: if (paramdata_0a) state_next = P_IDLE;
      default: state_next = P_IDLE;
    endcase
  end

  always_comb begin
    sel_value = '0;
    for (int i = 0; i < NUM_PARAMS; i++)
      if (paramaddr_0D == 32'(i)) sel_value = params[i];
  end

  // The value is captured at accept time so it stays stable even if the host rewrites it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= P_IDLE;
      ack_q  <= 1'b0;
      data_q <= '0;
    end else begin
      state <= state_next;
      ack_q <= load;
      if (load) data_q <= sel_value;
    end
  end

  assign paramaddr_0a  = ack_q;
  assign paramdata_0r0 = (state == P_RESP);
  assign paramdata_0D  = (state == P_RESP) ? data_q : '0;

endmodule

// File: rtl/sda_kernel_ctrl_regs.sv
// AXI-lite control/parameter register file that launches one kernel action,
// tracks its go/done handshake and raises DONE/IDLE status and an interrupt.
module sda_kernel_ctrl_regs
  import sda_kernel_ctrl_pkg::*;
#(
  parameter int NUM_PARAMS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic        go_0r,
  input  logic        go_0a,
  input  logic        done_0r,
  output logic        done_0a,
  input  logic        paramaddr_0r0,
  input  logic [31:0] paramaddr_0D,
  output logic        paramaddr_0a,
  output logic        paramdata_0r0,
  output logic [31:0] paramdata_0D,
  input  logic        paramdata_0a,
  output logic        irq
);

  action_state_t               a_state, a_next;
  logic [NUM_PARAMS-1:0][31:0] params;
  logic                        ie, done, busy;
  logic                        wr_fire, rd_fire;
  logic [5:0]                  wr_word, rd_word;
  int                          wr_pidx, rd_pidx;
  logic                        wr_is_ctrl, wr_is_ie, wr_is_param, wr_blocked;
  logic                        rd_is_ctrl, rd_is_ie;
  logic                        start_req, done_set, done_clr;
  logic [31:0]                 rd_value;
  logic                        addr_unused;

  assign busy    = (a_state != A_IDLE);
  assign wr_fire = s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid;
  assign rd_fire = s_axi_arvalid & ~s_axi_rvalid;
  assign s_axi_awready = wr_fire;
  assign s_axi_wready  = wr_fire;
  assign s_axi_arready = rd_fire;
  assign s_axi_rresp   = RESP_OKAY;

  assign wr_word     = s_axi_awaddr[7:2];
  assign rd_word     = s_axi_araddr[7:2];
  assign wr_pidx     = param_index(wr_word);
  assign rd_pidx     = param_index(rd_word);
  assign wr_is_ctrl  = (wr_word == CTRL_OFFSET[7:2]);
  assign wr_is_ie    = (wr_word == IE_OFFSET[7:2]);
  assign wr_is_param = (wr_pidx >= 0) && (wr_pidx < NUM_PARAMS);
  assign rd_is_ctrl  = (rd_word == CTRL_OFFSET[7:2]);
  assign rd_is_ie    = (rd_word == IE_OFFSET[7:2]);
  assign addr_unused = ^{s_axi_awaddr[31:8], s_axi_awaddr[1:0],
                         s_axi_araddr[31:8], s_axi_araddr[1:0]};

  // Parameters and IE are frozen while an action runs so served values never change mid-run.
  assign wr_blocked = busy & (wr_is_ie | wr_is_param);
  assign start_req  = wr_fire & wr_is_ctrl & s_axi_wstrb[0] & s_axi_wdata[CTRL_START_BIT] & ~busy;
  assign done_set   = (a_state == A_DRAIN) & ~done_0r;
  assign done_clr   = rd_fire & rd_is_ctrl;
  assign irq        = done & ie;

  always_comb begin
    a_next  = a_state;
    go_0r   = 1'b0;
    done_0a = 1'b0;
    case (a_state)
      A_IDLE:  if (start_req) a_next = A_GO;
      A_GO: begin
        go_0r = 1'b1;
        if (go_0a) a_next = A_RUN;
      end
      A_RUN:   if (done_0r) a_next = A_ACK;
      A_ACK: begin
        done_0a = 1'b1;
        a_next  = A_DRAIN;
      end
      A_DRAIN: if (!done_0r) a_next = A_IDLE;
      default: a_next = A_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) a_state <= A_IDLE;
    else       a_state <= a_next;
  end

  always_comb begin
    rd_value = '0;
    if (rd_is_ctrl) begin
      rd_value[CTRL_START_BIT] = busy;
      rd_value[CTRL_DONE_BIT]  = done;
      rd_value[CTRL_IDLE_BIT]  = ~busy;
    end else if (rd_is_ie) begin
      rd_value[0] = ie;
    end else begin
      for (int i = 0; i < NUM_PARAMS; i++)
        if (rd_pidx == i) rd_value = params[i];
    end
  end

  // NOTE: the parameter array is a handful of flops with a defined reset value, not a RAM, so it is reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      params       <= '0;
      ie           <= 1'b0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
    end else begin
      if (wr_fire) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_blocked ? RESP_SLVERR : RESP_OKAY;
        if (!busy) begin
          if (wr_is_ie && s_axi_wstrb[0]) ie <= s_axi_wdata[0];
          for (int i = 0; i < NUM_PARAMS; i++)
            if (wr_pidx == i)
              for (int b = 0; b < 4; b++)
                if (s_axi_wstrb[b]) params[i][8*b +: 8] <= s_axi_wdata[8*b +: 8];
        end
      end else if (s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
    end
  end

  // A CTRL read racing the DONE set returns the old DONE=0 and the set survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      done         <= 1'b0;
    end else begin
      if (rd_fire) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_value;
      end else if (s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
      if (done_set)      done <= 1'b1;
      else if (done_clr) done <= 1'b0;
    end
  end

  sda_param_server #(.NUM_PARAMS(NUM_PARAMS)) u_param_server (
    .clk          (clk),
    .reset        (reset),
    .params       (params),
    .paramaddr_0r0(paramaddr_0r0),
    .paramaddr_0D (paramaddr_0D),
    .paramaddr_0a (paramaddr_0a),
    .paramdata_0r0(paramdata_0r0),
    .paramdata_0D (paramdata_0D),
    .paramdata_0a (paramdata_0a)
  );

endmodule

// File: tb/tb_sda_kernel_ctrl_regs.sv
// Bench for sda_kernel_ctrl_regs: directed scenarios plus randomized traffic,
// all checked every cycle against a transaction-level model of the register file.
module tb_sda_kernel_ctrl_regs;

  localparam int NP = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] s_axi_awaddr = '0, s_axi_wdata = '0, s_axi_araddr = '0, s_axi_rdata;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_awvalid = 0, s_axi_wvalid = 0, s_axi_bready = 0, s_axi_arvalid = 0, s_axi_rready = 0;
  logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        go_0r, go_0a = 0, done_0r = 0, done_0a, irq;
  logic        paramaddr_0r0 = 0, paramaddr_0a, paramdata_0r0, paramdata_0a = 0;
  logic [31:0] paramaddr_0D = '0, paramdata_0D;

  sda_kernel_ctrl_regs #(.NUM_PARAMS(NP)) dut (
    .clk(clk), .reset(reset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .go_0r(go_0r), .go_0a(go_0a), .done_0r(done_0r), .done_0a(done_0a),
    .paramaddr_0r0(paramaddr_0r0), .paramaddr_0D(paramaddr_0D), .paramaddr_0a(paramaddr_0a),
    .paramdata_0r0(paramdata_0r0), .paramdata_0D(paramdata_0D), .paramdata_0a(paramdata_0a),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef enum {PH_IDLE, PH_GO, PH_RUN, PH_ACK, PH_DRAIN} phase_e;
  phase_e      ph;
  logic [31:0] m_prm [NP];
  logic        m_ie, m_done, m_bvalid, m_rvalid, ps_busy, ps_ack;
  logic [1:0]  m_bresp;
  logic [31:0] m_rdata, ps_data;

  task automatic model_reset();
    ph = PH_IDLE; m_ie = 0; m_done = 0; m_bvalid = 0; m_rvalid = 0;
    m_bresp = 2'b00; m_rdata = '0; ps_busy = 0; ps_ack = 0; ps_data = '0;
    for (int i = 0; i < NP; i++) m_prm[i] = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    int w;
    w = int'(addr[7:2]);
    if (w == 0) return {29'b0, ph == PH_IDLE, m_done, ph != PH_IDLE};
    if (w == 1) return {31'b0, m_ie};
    if (w >= 4 && w < 4 + NP) return m_prm[w-4];
    return '0;
  endfunction

  // Advances the model across the coming rising edge using the inputs now applied.
  task automatic model_step();
    logic busy, wr_fire, rd_fire, start, done_set, done_clr;
    int w;
    busy     = (ph != PH_IDLE);
    wr_fire  = s_axi_awvalid && s_axi_wvalid && !m_bvalid;
    rd_fire  = s_axi_arvalid && !m_rvalid;
    done_set = (ph == PH_DRAIN) && !done_0r;
    done_clr = rd_fire && (s_axi_araddr[7:2] == 6'd0);
    if (rd_fire) begin
      m_rvalid = 1; m_rdata = model_read(s_axi_araddr);
    end else if (m_rvalid && s_axi_rready) m_rvalid = 0;
    if (ps_busy) begin
      ps_ack = 0;
      if (paramdata_0a) ps_busy = 0;
    end else if (paramaddr_0r0) begin
      ps_busy = 1; ps_ack = 1;
      ps_data = (paramaddr_0D < NP) ? m_prm[paramaddr_0D[2:0]] : '0;
    end
    start = 0;
    if (wr_fire) begin
      w = int'(s_axi_awaddr[7:2]);
      m_bvalid = 1; m_bresp = 2'b00;
      if (w == 0) start = s_axi_wstrb[0] && s_axi_wdata[0] && !busy;
      else if (w == 1 || (w >= 4 && w < 4 + NP)) begin
        if (busy) m_bresp = 2'b10;
        else if (w == 1) begin
          if (s_axi_wstrb[0]) m_ie = s_axi_wdata[0];
        end else begin
          for (int b = 0; b < 4; b++)
            if (s_axi_wstrb[b]) m_prm[w-4][8*b +: 8] = s_axi_wdata[8*b +: 8];
        end
      end
    end else if (m_bvalid && s_axi_bready) m_bvalid = 0;
    case (ph)
      PH_IDLE:  if (start) ph = PH_GO;
      PH_GO:    if (go_0a) ph = PH_RUN;
      PH_RUN:   if (done_0r) ph = PH_ACK;
      PH_ACK:   ph = PH_DRAIN;
      default:  if (!done_0r) ph = PH_IDLE;
    endcase
    if (done_set) m_done = 1;
    else if (done_clr) m_done = 0;
  endtask

  // Compare process: every falling edge, DUT outputs against the model.
  initial begin
    logic [9:0] act_ctl, exp_ctl;
    forever begin
      @(negedge clk);
      if (reset) model_reset();
      act_ctl = {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid,
                 go_0r, done_0a, irq, paramaddr_0a, paramdata_0r0};
      exp_ctl = {s_axi_awvalid && s_axi_wvalid && !m_bvalid, s_axi_awvalid && s_axi_wvalid && !m_bvalid,
                 s_axi_arvalid && !m_rvalid, m_bvalid, m_rvalid,
                 ph == PH_GO, ph == PH_ACK, m_done && m_ie, ps_ack, ps_busy};
      check("ctl_outputs", 32'(act_ctl), 32'(exp_ctl));
      check("paramdata_0D", paramdata_0D, ps_busy ? ps_data : 32'h0);
      if (m_bvalid) check("bresp", 32'(s_axi_bresp), 32'(m_bresp));
      if (m_rvalid) begin
        check("rdata", s_axi_rdata, m_rdata);
        check("rresp", 32'(s_axi_rresp), 32'h0);
      end
      if (!reset) model_step();
    end
  end

  // ---------------- stimulus helpers (all start and end at posedge+1) ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit ok;
    ok = 0; resp = 2'b11;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
    s_axi_awvalid = 1; s_axi_wvalid = 1; s_axi_bready = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_axi_awready) begin ok = 1; break; end
    end
    cyc();
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    if (ok) begin
      ok = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (s_axi_bvalid) begin resp = s_axi_bresp; ok = 1; break; end
      end
      cyc();
    end
    check("write_handshake_done", 32'(ok), 32'h1);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
    bit ok;
    ok = 0; data = 32'hDEAD_BEEF;
    s_axi_araddr = addr; s_axi_arvalid = 1; s_axi_rready = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_axi_arready) begin ok = 1; break; end
    end
    cyc();
    s_axi_arvalid = 0;
    if (ok) begin
      ok = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (s_axi_rvalid) begin data = s_axi_rdata; ok = 1; break; end
      end
      cyc();
    end
    check("read_handshake_done", 32'(ok), 32'h1);
  endtask

  function automatic logic [31:0] rand_addr();
    int k;
    logic [31:0] noise;
    k = $urandom_range(0, 13);
    noise = $urandom() & 32'hFFFF_FF03;
    return noise | (32'((k < 12) ? k : 16 + k) << 2);
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0]  r;
    logic [31:0] d;

    repeat (3) cyc();
    @(negedge clk);
    check("reset_outputs_zero", 32'({go_0r, done_0a, irq, s_axi_bvalid, s_axi_rvalid,
                                     paramaddr_0a, paramdata_0r0}), 32'h0);
    cyc();
    reset = 0;
    cyc();

    // Parameter write / read-back and an unmapped read.
    for (int i = 0; i < NP; i++) begin
      axi_write(32'h10 + 32'(4*i), 32'hA0 + 32'(i), 4'hF, r);
      check("param_write_resp", 32'(r), 32'h0);
    end
    for (int i = 0; i < NP; i++) begin
      axi_read(32'h10 + 32'(4*i), d);
      check("param_readback", d, 32'hA0 + 32'(i));
    end
    axi_read(32'h40, d);
    check("unmapped_read", d, 32'h0);
    check("model_param5", m_prm[5], 32'hA5);

    // Enable interrupt, start the action.
    axi_write(32'h04, 32'h1, 4'hF, r);
    axi_read(32'h00, d);
    check("ctrl_idle", d, 32'h4);
    axi_write(32'h00, 32'h1, 4'hF, r);
    @(negedge clk); check("go_after_start", 32'(go_0r), 32'h1);
    cyc(); go_0a = 1;
    @(negedge clk); check("go_held_until_ack", 32'(go_0r), 32'h1);
    cyc(); go_0a = 0;
    @(negedge clk); check("go_dropped", 32'(go_0r), 32'h0);
    cyc();

    // Param reads during the run: index 3 with a 5-cycle stall, then index 9.
    paramaddr_0D = 32'd3; paramaddr_0r0 = 1;
    cyc(); paramaddr_0r0 = 0;
    @(negedge clk);
    check("paramaddr_ack", 32'(paramaddr_0a), 32'h1);
    check("param3_data", paramdata_0D, 32'hA3);
    cyc();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("param3_stall_valid", 32'({paramaddr_0a, paramdata_0r0}), 32'h1);
      check("param3_stall_data", paramdata_0D, 32'hA3);
      cyc();
    end
    paramdata_0a = 1;
    cyc(); paramdata_0a = 0;
    @(negedge clk); check("param_released", 32'(paramdata_0r0), 32'h0);
    cyc();
    paramaddr_0D = 32'd9; paramaddr_0r0 = 1;
    cyc(); paramaddr_0r0 = 0;
    @(negedge clk);
    check("param9_valid", 32'(paramdata_0r0), 32'h1);
    check("param9_data", paramdata_0D, 32'h0);
    cyc(); paramdata_0a = 1;
    cyc(); paramdata_0a = 0;

    // Write while busy is refused.
    axi_write(32'h18, 32'hFF, 4'hF, r);
    check("busy_write_slverr", 32'(r), 32'h2);
    axi_read(32'h18, d);
    check("busy_write_not_applied", d, 32'hA2);
    axi_read(32'h00, d);
    check("ctrl_busy", d, 32'h1);
    check("model_param2", m_prm[2], 32'hA2);

    // Completion handshake.
    done_0r = 1;
    @(negedge clk); check("done_ack_not_yet", 32'(done_0a), 32'h0);
    cyc();
    @(negedge clk); check("done_ack_pulse", 32'(done_0a), 32'h1);
    cyc();
    @(negedge clk); check("done_ack_one_cycle", 32'(done_0a), 32'h0);
    cyc(); done_0r = 0;
    cyc();
    @(negedge clk); check("irq_on_done", 32'(irq), 32'h1);
    cyc();
    axi_read(32'h00, d);
    check("ctrl_done_idle", d, 32'h6);
    check("irq_cleared", 32'(irq), 32'h0);
    axi_read(32'h00, d);
    check("ctrl_done_cleared", d, 32'h4);

    // DONE set in the same cycle as a CTRL read; go_0a and done_0r together in A_GO.
    axi_write(32'h00, 32'h1, 4'hF, r);
    go_0a = 1; done_0r = 1;
    cyc(); go_0a = 0;
    @(negedge clk); check("no_ack_skip", 32'({go_0r, done_0a}), 32'h0);
    cyc();
    @(negedge clk); check("ack_after_run", 32'(done_0a), 32'h1);
    cyc();
    done_0r = 0; s_axi_araddr = 32'h0; s_axi_arvalid = 1; s_axi_rready = 1;
    cyc(); s_axi_arvalid = 0;
    @(negedge clk);
    check("race_rvalid", 32'(s_axi_rvalid), 32'h1);
    check("race_read_done0", s_axi_rdata, 32'h1);
    cyc();
    axi_read(32'h00, d);
    check("race_done_kept", d, 32'h6);

    // Reset mid-run with a read response pending.
    axi_write(32'h00, 32'h1, 4'hF, r);
    go_0a = 1;
    cyc(); go_0a = 0;
    s_axi_rready = 0; s_axi_araddr = 32'h14; s_axi_arvalid = 1;
    cyc(); s_axi_arvalid = 0;
    @(negedge clk); check("rvalid_pending", 32'(s_axi_rvalid), 32'h1);
    cyc();
    reset = 1;
    #1;
    check("reset_midrun_outputs", 32'({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready,
                                        s_axi_rvalid, go_0r, done_0a, irq, paramaddr_0a,
                                        paramdata_0r0}), 32'h0);
    check("reset_midrun_data", s_axi_rdata | paramdata_0D, 32'h0);
    cyc(); cyc();
    reset = 0; s_axi_rready = 1;
    cyc();
    axi_read(32'h00, d);
    check("ctrl_after_reset", d, 32'h4);
    axi_read(32'h10, d);
    check("param_after_reset", d, 32'h0);
    check("model_param0", m_prm[0], 32'h0);

    // Randomized traffic on every interface.
    for (int n = 0; n < 4000; n++) begin
      reset         = ($urandom_range(0, 999) == 0);
      s_axi_awvalid = $urandom_range(0, 2) == 0;
      s_axi_wvalid  = s_axi_awvalid ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 5) == 0);
      s_axi_awaddr  = rand_addr();
      s_axi_wdata   = $urandom();
      s_axi_wstrb   = 4'($urandom_range(0, 15));
      s_axi_bready  = $urandom_range(0, 2) != 0;
      s_axi_arvalid = $urandom_range(0, 2) == 0;
      s_axi_araddr  = rand_addr();
      s_axi_rready  = $urandom_range(0, 2) != 0;
      go_0a         = $urandom_range(0, 1);
      done_0r       = $urandom_range(0, 3) == 0;
      paramaddr_0r0 = $urandom_range(0, 2) == 0;
      paramaddr_0D  = 32'($urandom_range(0, 11));
      paramdata_0a  = $urandom_range(0, 2) == 0;
      cyc();
    end

    reset = 0; s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
    s_axi_bready = 1; s_axi_rready = 1; go_0a = 0; done_0r = 0;
    paramaddr_0r0 = 0; paramdata_0a = 1;
    repeat (10) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
